riscv_mem_imm_unit: RTL and testbench

- Groups three single-cycle RV32I datapath support blocks behind one clock/reset:
  - instruction memory, fetch side, word-addressed by PC[7:2];
  - data memory, MEM stage, word-addressed by ALU result[7:2];
  - immediate generator, ID stage.
- Instruction memory is loaded through a write port, so test programs need no file I/O.

---
 rtl/riscv_mem_imm_unit.sv | 87 ++++++++
 tb/tb_riscv_mem_imm_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/riscv_mem_imm_unit.sv
// Single-cycle RV32I datapath support blocks sharing one clock/reset:
// a loadable instruction memory, a word-addressed data memory and the
// ID-stage immediate generator. Only memory contents are stateful.
module riscv_mem_imm_unit #(
   parameter int          AW            = 6,
   parameter int          DW            = 32,
   parameter logic [31:0] IMEM_RST_WORD = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] imem_addr,
   output logic [DW-1:0] imem_data,
   input  logic          imem_we,
   input  logic [AW-1:0] imem_waddr,
   input  logic [DW-1:0] imem_wdata,
   input  logic          dmem_mem_read,
   input  logic          dmem_mem_write,
   input  logic [AW-1:0] dmem_addr,
   input  logic [DW-1:0] dmem_wdata,
   output logic [DW-1:0] dmem_rdata,
   input  logic [31:0]   imm_inst,
   output logic [31:0]   imm_out
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_e;

   logic [DW-1:0] imem [DEPTH];
   logic [DW-1:0] dmem [DEPTH];

   // Instruction store: every word returns to a NOP on reset, then program load.
   // NOTE: resetting every word forbids RAM-macro inference; these are small
   // flop arrays on purpose so a reset leaves a known, runnable program.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) imem[i] <= DW'(IMEM_RST_WORD);
      end else if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   // Data store: cleared on reset, full-word store with no byte enables.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
      end else if (dmem_mem_write) begin
         dmem[dmem_addr] <= dmem_wdata;
      end
   end

   // Combinational reads; a same-address write shows up only after the edge.
   assign imem_data  = imem[imem_addr];
   assign dmem_rdata = dmem_mem_read ? dmem[dmem_addr] : '0;

   // Immediate decode by opcode; B and J results stay in halfword units.
   // NOTE: imm_out gets a default first so no opcode path can infer a latch.
   always_comb begin
      imm_out = '0;
      case (imm_inst[6:0])
         OP_LOAD, OP_IMM, OP_JALR:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31:20]};
         OP_STORE:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31:25], imm_inst[11:7]};
         OP_BRANCH:
            imm_out = {{20{imm_inst[31]}}, imm_inst[31], imm_inst[7],
                       imm_inst[30:25], imm_inst[11:8]};
         OP_LUI, OP_AUIPC:
            imm_out = {imm_inst[31:12], 12'b0};
         OP_JAL:
            imm_out = {{12{imm_inst[31]}}, imm_inst[31], imm_inst[19:12],
                       imm_inst[20], imm_inst[30:21]};
         default:
            imm_out = '0;
      endcase
   end

endmodule

// File: tb/tb_riscv_mem_imm_unit.sv
// Directed self-checking bench for riscv_mem_imm_unit.
module tb_riscv_mem_imm_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        dmem_mem_read;
   logic        dmem_mem_write;
   logic [5:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic [31:0] imm_inst;
   logic [31:0] imm_out;

   int checks   = 0;
   int failures = 0;

   riscv_mem_imm_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .imem_we        (imem_we),
      .imem_waddr     (imem_waddr),
      .imem_wdata     (imem_wdata),
      .dmem_mem_read  (dmem_mem_read),
      .dmem_mem_write (dmem_mem_write),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rdata     (dmem_rdata),
      .imm_inst       (imm_inst),
      .imm_out        (imm_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic imem_write(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   task automatic dmem_write(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      dmem_mem_write = 1'b1; dmem_addr = a; dmem_wdata = d;
      @(negedge clk);
      dmem_mem_write = 1'b0;
   endtask

   task automatic dmem_read(input logic [5:0] a, input logic rd, input logic [31:0] exp, input string tag);
      dmem_addr = a; dmem_mem_read = rd;
      #1;
      check(tag, dmem_rdata, exp);
   endtask

   task automatic imm_check(input logic [31:0] inst, input logic [31:0] exp, input string tag);
      imm_inst = inst;
      #1;
      check(tag, imm_out, exp);
   endtask

   initial begin
      rst = 1'b0;
      imem_addr = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      dmem_mem_read = 1'b0; dmem_mem_write = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      imm_inst = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset state
      imem_addr = 6'd0;  #1; check("rst_imem0", imem_data, 32'h0000_0013);
      imem_addr = 6'd42; #1; check("rst_imem42", imem_data, 32'h0000_0013);
      dmem_read(6'd5, 1'b1, 32'h0, "rst_dmem5");

      // Program load
      imem_write(6'd0, 32'h0050_0093);
      imem_write(6'd1, 32'h00A0_0113);
      imem_addr = 6'd0; #1; check("imem_ld0", imem_data, 32'h0050_0093);
      imem_addr = 6'd1; #1; check("imem_ld1", imem_data, 32'h00A0_0113);
      @(negedge clk);
      imem_we = 1'b0; imem_waddr = 6'd1; imem_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("imem_we0", imem_data, 32'h00A0_0113);

      // Data store/load
      dmem_write(6'd3, 32'hDEAD_BEEF);
      dmem_read(6'd3, 1'b1, 32'hDEAD_BEEF, "dmem3_rd");
      dmem_read(6'd3, 1'b0, 32'h0, "dmem3_nord");
      dmem_write(6'd63, 32'h1234_5678);
      dmem_read(6'd63, 1'b1, 32'h1234_5678, "dmem63");
      dmem_read(6'd0, 1'b1, 32'h0, "dmem0_clean");

      // Same-address read+write: old before the edge, new after
      dmem_write(6'd7, 32'h0000_0011);
      @(negedge clk);
      dmem_addr = 6'd7; dmem_mem_read = 1'b1; dmem_mem_write = 1'b1; dmem_wdata = 32'h22;
      #1; check("rw_before", dmem_rdata, 32'h0000_0011);
      @(posedge clk); #1;
      dmem_mem_write = 1'b0;
      check("rw_after", dmem_rdata, 32'h0000_0022);

      // Immediates
      imm_check(32'hFFF0_0093, 32'hFFFF_FFFF, "imm_addi");
      imm_check(32'h0081_2223, 32'h0000_0004, "imm_sw");
      imm_check(32'h00A0_2083, 32'h0000_000A, "imm_lw");
      imm_check(32'h0020_8463, 32'h0000_0004, "imm_beq_p8");
      imm_check(32'hFE20_8EE3, 32'hFFFF_FFFE, "imm_beq_m4");
      imm_check(32'h1234_50B7, 32'h1234_5000, "imm_lui");
      imm_check(32'h0080_00EF, 32'h0000_0004, "imm_jal");
      imm_check(32'h0020_81B3, 32'h0000_0000, "imm_add");

      // Asynchronous mid-cycle reset clears memories without an edge
      @(negedge clk);
      #2;
      rst = 1'b0;
      imem_addr = 6'd0; dmem_addr = 6'd3; dmem_mem_read = 1'b1;
      #1;
      check("arst_imem0", imem_data, 32'h0000_0013);
      check("arst_dmem3", dmem_rdata, 32'h0);
      dmem_addr = 6'd63; #1;
      check("arst_dmem63", dmem_rdata, 32'h0);
      // Immediate generator is unaffected by reset
      imm_check(32'h1234_50B7, 32'h1234_5000, "arst_imm");

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
